// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sorted-list
// removal path.
package sort_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int IDX_W = 8;

  typedef logic [DEF_WIDTH-1:0] key_t;

  typedef enum logic {
    RSP_IDLE,
    RSP_BUSY
  } rsp_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rank_counter.sv
// Rank of a key within the occupied, ascending part of
// the list, plus a flag telling whether the key is stored.
module rank_counter
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 100
) (
  input  logic [WIDTH-1:0]          key,
  input  logic [WIDTH-1:0]          entries [DEPTH],
  input  logic [cnt_w(DEPTH)-1:0]   count,
  output logic [IDX_W-1:0]          rank,
  output logic                      match
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [CNT_W-1:0] acc;

  // Sorted storage: any equal entry sits exactly at the rank.
  always_comb begin
    acc   = '0;
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (entries[i] < key)
          acc = acc + CNT_W'(1);
        if (entries[i] == key)
          match = 1'b1;
      end
    end
    rank = IDX_W'(acc);
  end

endmodule

// File: rtl/sorted_list_remove.sv
// Registered ascending key store with ordered load,
// keyed delete with compaction and minimum pop.
module sorted_list_remove
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     del_valid,
  output logic                     del_ready,
  input  logic [WIDTH-1:0]         del_key,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_found,
  output logic [IDX_W-1:0]         resp_index,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     ord_err
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] ent     [DEPTH];
  logic [WIDTH-1:0] ent_nxt [DEPTH];
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] last;
  logic [IDX_W-1:0] rank;
  logic [IDX_W-1:0] shift_from;
  logic             found;
  logic             load_ok;
  logic             shift_en;
  logic             oe_nxt;
  logic             del_fire;
  logic             pop_fire;
  logic             load_fire;
  rsp_state_e       state;
  rsp_state_e       state_nxt;

  rank_counter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rank (
    .key     (del_key),
    .entries (ent),
    .count   (count),
    .rank    (rank),
    .match   (found)
  );

  assign resp_valid = (state == RSP_BUSY);
  assign del_ready  = !resp_valid | resp_ready;
  assign del_fire   = del_valid & del_ready;
  assign pop_valid  = (count != '0) & !del_valid;
  assign pop_fire   = pop_valid & pop_ready;
  assign load_ready = (count < CNT_W'(DEPTH))
                    & !del_valid & !pop_fire;
  assign load_fire  = load_valid & load_ready;
  assign pop_data   = ent[0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      RSP_IDLE: if (del_fire) state_nxt = RSP_BUSY;
      RSP_BUSY: if (resp_ready & !del_fire) state_nxt = RSP_IDLE;
      default:  state_nxt = RSP_IDLE;
    endcase
  end

  // Pop and found-delete share one shift-down path; entries
  // past count are zero so the tail zero-fills naturally.
  always_comb begin
    last = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i + 1) == count)
        last = ent[i];
    load_ok    = (count == '0) | !(load_data < last);
    shift_en   = pop_fire | (del_fire & found);
    shift_from = del_fire ? rank : '0;
    ent_nxt    = ent;
    count_nxt  = count;
    oe_nxt     = ord_err;
    if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= shift_from)
          ent_nxt[i] = ent[i + 1];
      ent_nxt[DEPTH-1] = '0;
      count_nxt = count - CNT_W'(1);
    end else if (load_fire) begin
      if (load_ok) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == count)
            ent_nxt[i] = load_data;
        count_nxt = count + CNT_W'(1);
      end else begin
        oe_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RSP_IDLE;
      count      <= '0;
      ord_err    <= 1'b0;
      resp_found <= 1'b0;
      resp_index <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      ord_err <= oe_nxt;
      ent     <= ent_nxt;
      if (del_fire) begin
        resp_found <= found;
        resp_index <= rank;
      end
    end
  end

endmodule

// File: doc/sorted_list_remove.md
Name: sorted_list_remove

Overview:
- Sequential, registered sorted-list store of up to DEPTH unsigned entries, held in ascending order.
- Provides the removal direction for the sorted-array merge/insert path:
  - loads an already-sorted list;
  - deletes a keyed entry and compacts the array;
  - streams out the minimum entry (pop).
- Sits downstream of the insert/merge stage and feeds consumers that retire sorted keys.

Parameters:
- WIDTH, 16: key/data width in bits; unsigned compare.
- DEPTH, 100: maximum stored entries; must be <= 255 (index fits 8 bits).
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  append request.
- load_ready  out  1  append accepted when load_valid & load_ready.
- load_data  in  WIDTH  value appended at index count.
- del_valid  in  1  delete request.
- del_ready  out  1  delete accepted when del_valid & del_ready.
- del_key  in  WIDTH  key to remove.
- resp_valid  out  1  delete response valid.
- resp_ready  in  1  response consumed.
- resp_found  out  1  key was present and removed.
- resp_index  out  8  rank of key: number of stored entries strictly less than del_key.
- pop_valid  out  1  minimum available.
- pop_ready  in  1  consumer takes minimum.
- pop_data  out  WIDTH  entry[0].
- count  out  CNT_W  current occupancy.
- ord_err  out  1  sticky: an out-of-order load was dropped.

Behaviour:
- Reset (sync, active-high): count=0, all entries=0, resp_valid=0, resp_found=0, resp_index=0, ord_err=0. rst overrides every same-cycle handshake. A pending response is discarded; an accepted-but-unresponded delete is lost.
- Storage: entry[0..count-1] non-decreasing; entries at index >= count are always 0.
- Arbitration, one operation per cycle, priority delete > pop > load:
  - del_ready = !resp_valid | resp_ready.
  - pop_valid = (count!=0) & !del_valid.
  - load_ready = (count<DEPTH) & !del_valid & !(pop_valid & pop_ready).
  - Readies depend on same-cycle valids; no combinational path from any ready back to a valid.
- Delete (fire at edge T):
  - rank r = number of i<count with entry[i] < del_key.
  - found = (r<count) & (entry[r]==del_key).
  - If found: entry[i] <= entry[i+1] for r <= i < count-1; entry[count-1] <= 0; count decrements.
  - Duplicates: only the lowest-index match is removed.
  - At the same edge: resp_valid <= 1, resp_found <= found, resp_index <= r (truncated to 8 bits). Response is visible the cycle after acceptance.
  - Response fields hold stable until resp_valid & resp_ready.
  - Back-to-back: resp_ready=1 allows a new delete in the same cycle the old response retires; resp_valid stays 1 with the new fields.
- Pop (pop_valid & pop_ready):
  - pop_data = entry[0], combinational from the register.
  - At the edge: all entries shift down by one, the top is zero-filled, count decrements.
- Load (fire):
  - If count!=0 and load_data < entry[count-1]: data is dropped, ord_err <= 1, count unchanged.
  - Otherwise entry[count] <= load_data and count increments.
  - Full (count==DEPTH): load_ready=0.
- Empty: pop_valid=0; a delete still fires and returns found=0, index=0.
- Key larger than all entries: found=0, resp_index=count.
- Rank logic is a DEPTH-wide compare array with a popcount; single-cycle, no pipelining.

Decomposition:
- Package sort_pkg: WIDTH default, IDX_W=8, clog2-based CNT_W helper, key typedef logic [WIDTH-1:0].
- One sub-module, rank_counter (params WIDTH, DEPTH). Inputs: key, entry array, count. Outputs: rank (8b) and match-at-rank flag.
- Shift/compaction and handshake FSM stay in the top.

Test Plan:
- Reset, then load 10,20,20,30 -> count=4, pop_data=10, ord_err=0. Then load 25 -> dropped, ord_err=1, count=4.
- With [10,20,20,30], delete 20 -> next cycle resp_found=1, resp_index=1; array becomes [10,20,30,0], count=3.
- Delete 15 -> found=0, index=1, array unchanged. Delete 99 -> found=0, index=3.
- Hold resp_ready=0 after a delete -> del_ready=0 and response fields stable for 5 cycles. Then resp_ready=1 with del_valid=1 (key 10) -> new response next cycle.
- del_valid, pop_ready and load_valid all high in the same cycle -> only the delete fires; pop_valid=0, load_ready=0.
- Fill to DEPTH=100 with 0..99 -> load_ready=0. Pop 100 times -> pop_data sequence 0..99, count=0, pop_valid=0. Assert rst mid-response -> resp_valid=0, count=0 next cycle.
